// File: rtl/aes_pkg.sv
// Shared AES helpers: byte lanes, GF(2^8) xtime, ShiftRows and MixColumns.
// Used by both the encrypt round tail and the decrypt-side inverse stages.
package aes_pkg;

  localparam int STATE_W = 128;

  typedef logic [7:0]         byte_t;
  typedef logic [STATE_W-1:0] state_t;

  // Buffer occupancy encoded as {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_e;

  // Byte k sits at bits [127-8k -: 8]; k = 4*col + row.
  function automatic byte_t get_byte(input state_t s, input int unsigned k);
    return s[STATE_W-1-8*k -: 8];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic state_t shift_rows(input state_t s);
    state_t res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[STATE_W-1-8*(4*c+r) -: 8] = get_byte(s, 4*((c+r)%4) + r);
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] col);
    byte_t b0, b1, b2, b3;
    {b0, b1, b2, b3} = col;
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t res;
    for (int c = 0; c < 4; c++) begin
      res[STATE_W-1-32*c -: 32] = mix_word(s[STATE_W-1-32*c -: 32]);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// One AES MixColumns column: fixed 2 3 1 1 circulant over GF(2^8), XOR only.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  byte_t b0, b1, b2, b3;
  byte_t x0, x1, x2, x3;

  assign {b0, b1, b2, b3} = col;

  assign x0 = xtime(b0);
  assign x1 = xtime(b1);
  assign x2 = xtime(b2);
  assign x3 = xtime(b3);

  // 3*b is xtime(b) ^ b, so each output row is four XOR terms plus doublings.
  assign mixed[31:24] = x0 ^ x1 ^ b1 ^ b2 ^ b3;
  assign mixed[23:16] = b0 ^ x1 ^ x2 ^ b2 ^ b3;
  assign mixed[15:8]  = b0 ^ b1 ^ x2 ^ x3 ^ b3;
  assign mixed[7:0]   = x0 ^ b0 ^ b1 ^ b2 ^ x3;

endmodule

// File: rtl/aes_round_tail.sv
// AES-128 encryption round back-end: ShiftRows, MixColumns (bypassed on the
// final round) and AddRoundKey, registered behind a 2-entry skid buffer.
module aes_round_tail
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] round_key,
  input  logic               final_round,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               out_final
);

  state_t sr, mc, result;

  assign sr = shift_rows(state_in);

  for (genvar g = 0; g < 4; g++) begin : g_mix
    aes_mix_column u_mix (
      .col   (sr[STATE_W-1-32*g -: 32]),
      .mixed (mc[STATE_W-1-32*g -: 32])
    );
  end

  assign result = (final_round ? sr : mc) ^ round_key;

  occ_e             occ_q, occ_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;
  logic             load_main_new, load_main_skid, load_skid;
  state_t           skid_state;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_final;

  assign out_valid = occ_q[1];
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    occ_d          = occ_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          occ_d         = OCC_ONE;
          load_main_new = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          load_main_new = 1'b1;
        end else if (in_fire) begin
          occ_d     = OCC_FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_fire) begin
          occ_d          = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // in_ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
      state_out  <= '0;
      tag_out    <= '0;
      out_final  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != OCC_FULL);
      if (load_main_new) begin
        state_out <= result;
        tag_out   <= tag_in;
        out_final <= final_round;
      end else if (load_main_skid) begin
        state_out <= skid_state;
        tag_out   <= skid_tag;
        out_final <= skid_final;
      end
    end
  end

  // NOTE: skid payload needs no reset; it is only ever read while occupancy marks it valid.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_state <= result;
      skid_tag   <= tag_in;
      skid_final <= final_round;
    end
  end

endmodule

// File: tb/tb_aes_round_tail.sv
// Self-checking bench for aes_round_tail: byte-array AES reference model and a
// depth-2 FIFO model of the handshake, directed vectors plus random traffic.
module tb_aes_round_tail;

  localparam int TAG_W = 4;

  typedef struct {
    logic [127:0]     s;
    logic [TAG_W-1:0] tag;
    logic             fin;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [127:0]     state_in, round_key;
  logic             final_round;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid, out_ready;
  logic [127:0]     state_out;
  logic [TAG_W-1:0] tag_out;
  logic             out_final;

  aes_round_tail #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .round_key   (round_key),
    .final_round (final_round),
    .tag_in      (tag_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out),
    .tag_out     (tag_out),
    .out_final   (out_final)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  ent_t             q[$];
  logic [TAG_W-1:0] seen[$];
  logic             rdy_mod;
  logic             last_in_fire;

  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if ((m >> i) & 1) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic fin);
    logic [7:0] a[4][4];
    logic [7:0] b[4][4];
    logic [7:0] o[4][4];
    logic [127:0] res;
    int coef[4][4];
    coef = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r][c] = st[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[r][c] = a[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (fin) o[r][c] = b[r][c];
        else begin
          o[r][c] = 8'h00;
          for (int k = 0; k < 4; k++) o[r][c] = o[r][c] ^ gmul(b[k][c], coef[r][k]);
        end
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = o[r][c];
    return res ^ key;
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: transfers predicted by the model, then outputs checked #1 after the edge.
  task automatic cycle();
    logic in_f, out_f;
    ent_t e;
    in_f  = in_valid && rdy_mod;
    out_f = (q.size() > 0) && out_ready;
    e.s   = ref_round(state_in, round_key, final_round);
    e.tag = tag_in;
    e.fin = final_round;
    if (out_f) seen.push_back(tag_out);
    @(posedge clk);
    if (out_f) void'(q.pop_front());
    if (in_f) q.push_back(e);
    rdy_mod = (q.size() < 2);
    last_in_fire = in_f;
    #1;
    check("in_ready", {127'b0, in_ready}, {127'b0, rdy_mod});
    check("out_valid", {127'b0, out_valid}, {127'b0, q.size() > 0});
    if (q.size() > 0) begin
      check("state_out", state_out, q[0].s);
      check("tag_out", {124'b0, tag_out}, {124'b0, q[0].tag});
      check("out_final", {127'b0, out_final}, {127'b0, q[0].fin});
    end
  endtask

  task automatic drive_random(input int valid_pct);
    state_in    = {$urandom, $urandom, $urandom, $urandom};
    round_key   = {$urandom, $urandom, $urandom, $urandom};
    final_round = 1'($urandom_range(0, 1));
    tag_in      = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
    in_valid    = ($urandom_range(0, 99) < valid_pct);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; final_round = 1'b0;
    state_in = '0; round_key = '0; tag_in = '0;
    rdy_mod = 1'b0; last_in_fire = 1'b0;
    #23;
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_in_ready", {127'b0, in_ready}, 128'd0);
    check("rst_state_out", state_out, 128'd0);
    check("rst_tag_final", {123'b0, tag_out, out_final}, 128'd0);
    rst_n = 1'b1;
    cycle();

    // FIPS-197 round 1, final-round bypass, MixColumns only.
    out_ready = 1'b1; in_valid = 1'b1; tag_in = 4'h3;
    state_in = 128'hd42711aee0bf98f1b8b45de51e415230;
    round_key = 128'ha0fafe1788542cb123a339392a6c7605;
    final_round = 1'b0;
    cycle();
    check("fips_round1", state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
    round_key = '0; final_round = 1'b1;
    cycle();
    check("final_bypass", state_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("final_flag", {127'b0, out_final}, 128'd1);
    final_round = 1'b0;
    cycle();
    check("mixcol_only", state_out, 128'h046681e5e0cb199a48f8d37a2806264c);
    in_valid = 1'b0;
    cycle();

    // Backpressure: tags 1..6 back-to-back, consumer stalled for 3 cycles.
    seen.delete();
    t = 1; out_ready = 1'b0;
    for (int i = 0; i < 30 && (t <= 6 || q.size() > 0); i++) begin
      drive_random(100);
      in_valid = (t <= 6);
      tag_in = TAG_W'(t);
      out_ready = (i >= 3);
      if (i == 2) check("bp_in_ready_low", {127'b0, in_ready}, 128'd0);
      cycle();
      if (last_in_fire) t++;
    end
    check("bp_count", 128'(seen.size()), 128'd6);
    for (int i = 0; i < seen.size() && i < 6; i++)
      check("bp_order", {124'b0, seen[i]}, 128'(i + 1));

    // Accept and drain together for 16 cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_random(100);
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Reset asserted while FULL.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random(100);
      cycle();
    end
    check("full_before_rst", 128'(q.size()), 128'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {127'b0, out_valid}, 128'd0);
    check("async_in_ready", {127'b0, in_ready}, 128'd0);
    check("async_state_out", state_out, 128'd0);
    q.delete(); rdy_mod = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    drive_random(100);
    cycle();
    cycle();

    // Random traffic; upstream holds a state until it is accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_in_fire)) drive_random(70);
      out_ready = ($urandom_range(0, 99) < 60);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
